mips_cpu_muldiv_seq: RTL and testbench
======================================

MIPS_CPU_MULDIV_SEQ -- requirements
Module: mips_cpu_muldiv_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request a multiply/divide; sampled only in IDLE.
REQ-004 The block SHALL have the port op, input, 2 bits: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV.
REQ-005 The block SHALL have the ports a and b, inputs, 32 bits each: multiplicand/multiplier or dividend/divisor, sampled with start.
REQ-006 The block SHALL have the ports hi_we and lo_we, inputs, 1 bit each, and hilo_wdata, input, 32 bits: MTHI/MTLO write port.
REQ-007 The block SHALL have the port alu_req, output, 1 bit: requests the shared ALU.
REQ-008 The block SHALL have the port alu_gnt, input, 1 bit: ALU granted this cycle.
REQ-009 The block SHALL have the ports alu_op, output, 4 bits; alu_a and alu_b, outputs, 32 bits each; and alu_result, input, 32 bits: shared ALU operands and result, using op 2=add and 3=sub.
REQ-010 The block SHALL have the port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have the ports hi and lo, outputs, 32 bits each: architectural HI/LO registers.
REQ-013 The block SHALL have the port div_zero, output, 1 bit: the last divide had divisor 0.

Function
REQ-014 The block SHALL implement the FSM states IDLE, PREP, ITER, FIX and DONE.
REQ-015 IDLE: start=1 SHALL latch op, a and b, set busy=1 and enter PREP; start SHALL be ignored in every other state.
REQ-016 PREP (1 cycle): for signed ops the block SHALL take local absolute values and record the result/remainder signs, clear the iteration counter, and enter ITER.
REQ-017 ITER SHALL hold alu_req=1 and SHALL advance one bit per cycle only when alu_gnt=1; with alu_gnt=0 all state SHALL hold.
REQ-018 MULTU/MULT SHALL use shift-add: if the multiplier LSB=1 the ALU SHALL add (op 2) the partial HI and the multiplicand, carry = (alu_result < alu_a) unsigned, and {carry,sum,LO} SHALL shift right 1.
REQ-019 DIVU/DIV SHALL use restoring division: {rem,quot} shifts left 1, the ALU SHALL subtract (op 3) the divisor, and the difference SHALL be committed with quotient bit 1 iff the shifted 33-bit remainder >= divisor, else quotient bit 0.
REQ-020 After exactly 32 granted ITER cycles the block SHALL enter FIX.
REQ-021 FIX (1 cycle): the block SHALL apply two's-complement sign correction to the product, quotient and remainder (remainder takes the dividend's sign), then write hi and lo.
REQ-022 On divisor=0 in either divide op, FIX SHALL force hi=a, lo=32'hFFFFFFFF and div_zero=1; any other divide SHALL clear div_zero, and multiplies SHALL leave it unchanged.
REQ-023 DONE SHALL pulse done=1 for one cycle, then the block SHALL return to IDLE with busy=0.
REQ-024 With alu_gnt held at 1, done SHALL assert in the 35th cycle after the start edge; each alu_gnt=0 cycle in ITER SHALL add exactly one cycle.
REQ-025 alu_req SHALL be 0 outside ITER, and alu_op/alu_a/alu_b SHALL be 0 when alu_req=0.
REQ-026 hi_we/lo_we SHALL write hilo_wdata into hi/lo only in IDLE; start and a write in the same cycle SHALL take start, and the write SHALL be dropped.
REQ-027 hi and lo SHALL hold their values while busy and until the next write or completion.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, busy=0, done=0, alu_req=0, hi=0, lo=0, div_zero=0, and clear the counter, including mid-operation.
REQ-029 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 With MULDIV_SIGNED_EN defined, MULT and DIV SHALL be signed as specified above.
REQ-031 Without MULDIV_SIGNED_EN, op[0] SHALL be ignored (all ops unsigned), PREP SHALL perform no sign capture, FIX SHALL perform no sign correction, and latency SHALL be unchanged.

Verification
REQ-032 A bench SHALL drive MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF with gnt=1 and require hi=32'hFFFFFFFE, lo=1 and done at cycle 35.
REQ-033 A bench SHALL drive DIVU a=100, b=7 and require lo=14, hi=2, div_zero=0.
REQ-034 A bench SHALL drive DIV a=-7, b=2 and MULT a=-3, b=5 with MULDIV_SIGNED_EN defined and require lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, then hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-035 A bench SHALL drive DIVU a=32'h1234, b=0 and require hi=32'h1234, lo=32'hFFFFFFFF, div_zero=1.
REQ-036 A bench SHALL drive MULTU 6x7 with gnt=0 for 10 cycles mid-ITER and require done at cycle 45 and lo=42.
REQ-037 A bench SHALL assert reset at ITER cycle 10, then a start with hi_we in the same cycle, and require all outputs 0 after reset, the write dropped, and a correct result.

Source files
------------

// File: rtl/mips_cpu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_seq_if
// Description : Bundle of the request, HI/LO write, shared-ALU and result
//               signals of the sequential multiply/divide unit.
//               slave  - the multiply/divide unit itself
//               master - the CPU / ALU-arbiter side that talks to it
// Signals     : start, op[1:0], a[31:0], b[31:0]          request
//               hi_we, lo_we, hilo_wdata[31:0]            MTHI/MTLO write
//               alu_req, alu_gnt, alu_op[3:0],
//               alu_a[31:0], alu_b[31:0], alu_result[31:0] shared ALU
//               busy, done, hi[31:0], lo[31:0], div_zero   status / results
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_cpu_muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        alu_req;
  logic        alu_gnt;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport slave (
    input  start, op, a, b, hi_we, lo_we, hilo_wdata, alu_gnt, alu_result,
    output alu_req, alu_op, alu_a, alu_b, busy, done, hi, lo, div_zero
  );

  modport master (
    output start, op, a, b, hi_we, lo_we, hilo_wdata, alu_gnt, alu_result,
    input  alu_req, alu_op, alu_a, alu_b, busy, done, hi, lo, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_seq
// Description : Sequential MIPS HI/LO multiply/divide unit. One bit per
//               granted cycle on a shared ALU: shift-add multiply, restoring
//               divide. Sequence IDLE -> PREP -> ITER(x32) -> FIX -> DONE.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-high reset
//               bus    - mips_cpu_muldiv_seq_if.slave (request, MTHI/MTLO
//                        write, shared-ALU handshake, busy/done, hi/lo,
//                        div_zero)
// Config      : MULDIV_SIGNED_EN - when defined, op[0]=1 selects signed
//               MULT/DIV (magnitudes in PREP, sign fix-up in FIX). When
//               undefined every op is unsigned; latency is identical.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv_seq (
  input  wire logic             clk,
  input  wire logic             reset,
  mips_cpu_muldiv_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [5:0] LAST_BIT = 6'd31;

  logic [2:0]  state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [31:0] acc_hi_q, acc_hi_d;   // partial HI / running remainder
  logic [31:0] acc_lo_q, acc_lo_d;   // multiplier->LO / dividend->quotient
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;
`ifdef MULDIV_SIGNED_EN
  logic        is_signed_q, is_signed_d;
  logic        neg_res_q, neg_res_d;  // product / quotient negative
  logic        neg_rem_q, neg_rem_d;  // remainder follows the dividend
`endif

  logic        step;
  logic [31:0] a_mag, b_mag;
  logic [31:0] rem_shift;
  logic        rem_ge;
  logic        carry;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      is_signed_q <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opnd_q     <= opnd_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      is_signed_q <= is_signed_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_PREP;
      S_PREP:  state_d = S_ITER;
      S_ITER:  if (bus.alu_gnt && (cnt_q == LAST_BIT)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------- arithmetic helpers
  assign step = (state_q == S_ITER) && bus.alu_gnt;

  // Remainder after the left shift; bit 32 is acc_hi_q[31]. If that bit is
  // set the 33-bit value certainly exceeds any 32-bit divisor.
  assign rem_shift = {acc_hi_q[30:0], acc_lo_q[31]};
  assign rem_ge    = acc_hi_q[31] || (rem_shift >= opnd_q);

  // Multiply always adds (multiplicand or zero), so carry is just the
  // unsigned wrap-around of the ALU sum.
  assign carry = (bus.alu_result < acc_hi_q);

`ifdef MULDIV_SIGNED_EN
  assign a_mag    = (is_signed_q && a_q[31]) ? (32'd0 - a_q) : a_q;
  assign b_mag    = (is_signed_q && b_q[31]) ? (32'd0 - b_q) : b_q;
  assign prod_fix = neg_res_q ? (64'd0 - {acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
  assign quot_fix = neg_res_q ? (32'd0 - acc_lo_q) : acc_lo_q;
  assign rem_fix  = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;
`else
  assign a_mag    = a_q;
  assign b_mag    = b_q;
  assign prod_fix = {acc_hi_q, acc_lo_q};
  assign quot_fix = acc_lo_q;
  assign rem_fix  = acc_hi_q;
`endif

  // ------------------------------------------------------------- datapath
  always_comb begin
    is_div_d   = is_div_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
`ifdef MULDIV_SIGNED_EN
    is_signed_d = is_signed_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // A start wins over a same-cycle MTHI/MTLO, which is dropped.
          is_div_d = bus.op[1];
          a_d      = bus.a;
          b_d      = bus.b;
`ifdef MULDIV_SIGNED_EN
          is_signed_d = bus.op[0];
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.hilo_wdata;
          if (bus.lo_we) lo_d = bus.hilo_wdata;
        end
      end
      S_PREP: begin
        cnt_d    = '0;
        acc_hi_d = '0;
        acc_lo_d = is_div_q ? a_mag : b_mag;
        opnd_d   = is_div_q ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = is_signed_q && (a_q[31] ^ b_q[31]);
        neg_rem_d = is_signed_q && a_q[31];
`endif
      end
      S_ITER: begin
        if (step) begin
          cnt_d = cnt_q + 6'd1;
          if (is_div_q) begin
            acc_hi_d = rem_ge ? bus.alu_result : rem_shift;
            acc_lo_d = {acc_lo_q[30:0], rem_ge};
          end else begin
            acc_hi_d = {carry, bus.alu_result[31:1]};
            acc_lo_d = {bus.alu_result[0], acc_lo_q[31:1]};
          end
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          if (opnd_q == 32'd0) begin
            hi_d       = a_q;
            lo_d       = 32'hFFFF_FFFF;
            div_zero_d = 1'b1;
          end else begin
            hi_d       = rem_fix;
            lo_d       = quot_fix;
            div_zero_d = 1'b0;
          end
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.alu_req  = (state_q == S_ITER);
    bus.alu_op   = 4'd0;
    bus.alu_a    = 32'd0;
    bus.alu_b    = 32'd0;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    bus.div_zero = div_zero_q;
    if (state_q == S_ITER) begin
      if (is_div_q) begin
        bus.alu_op = ALU_SUB;
        bus.alu_a  = rem_shift;
        bus.alu_b  = opnd_q;
      end else begin
        bus.alu_op = ALU_ADD;
        bus.alu_a  = acc_hi_q;
        bus.alu_b  = acc_lo_q[0] ? opnd_q : 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_muldiv_seq
// Description : Directed self-checking bench for mips_cpu_muldiv_seq with a
//               behavioural shared ALU (2=add, 3=sub). Signed expectations
//               follow MULDIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_muldiv_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;

  mips_cpu_muldiv_seq_if bus_if ();

  mips_cpu_muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  assign bus_if.alu_result = (bus_if.alu_op == 4'd2) ? (bus_if.alu_a + bus_if.alu_b) :
                             (bus_if.alu_op == 4'd3) ? (bus_if.alu_a - bus_if.alu_b) : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation from IDLE; cyc returns the cycle (1 = first cycle
  // after the start edge) in which done was seen. Grant is withheld for
  // cycles [st, st+sl).
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int st, input int sl, output int n);
    bus_if.start = 1'b1;
    bus_if.op    = o;
    bus_if.a     = x;
    bus_if.b     = y;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.hi_we = 1'b0;
    bus_if.lo_we = 1'b0;
    n = 1;
    check("prep_busy", bus_if.busy, 1);
    check("prep_req", bus_if.alu_req, 0);
    check("prep_aluop", bus_if.alu_op, 0);
    while (!bus_if.done && n < 200) begin
      bus_if.alu_gnt = !(n >= st && n < st + sl);
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        check("iter_req", bus_if.alu_req, 1);
        check("iter_aluop", bus_if.alu_op, o[1] ? 3 : 2);
      end
    end
    bus_if.alu_gnt = 1'b1;
    @(posedge clk); #1;
    check("done_pulse", bus_if.done, 0);
    check("idle_busy", bus_if.busy, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.op         = 2'd0;
    bus_if.a          = 32'd0;
    bus_if.b          = 32'd0;
    bus_if.hi_we      = 1'b0;
    bus_if.lo_we      = 1'b0;
    bus_if.hilo_wdata = 32'd0;
    bus_if.alu_gnt    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_req", bus_if.alu_req, 0);
    check("rst_hi", bus_if.hi, 0);
    check("rst_lo", bus_if.lo, 0);
    check("rst_dz", bus_if.div_zero, 0);
    reset = 1'b0;

    // MULTU all-ones squared, started on the first edge after reset
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, cyc);
    check("multu_lat", cyc, 35);
    check("multu_hi", bus_if.hi, 64'hFFFF_FFFE);
    check("multu_lo", bus_if.lo, 1);

    // DIVU 100 / 7
    do_op(2'd2, 32'd100, 32'd7, 0, 0, cyc);
    check("divu_lat", cyc, 35);
    check("divu_lo", bus_if.lo, 14);
    check("divu_hi", bus_if.hi, 2);
    check("divu_dz", bus_if.div_zero, 0);

    // DIVU by zero
    do_op(2'd2, 32'h1234, 32'd0, 0, 0, cyc);
    check("div0_hi", bus_if.hi, 32'h1234);
    check("div0_lo", bus_if.lo, 64'hFFFF_FFFF);
    check("div0_dz", bus_if.div_zero, 1);

    // MULTU 6 x 7 with 10 grant-free ITER cycles; div_zero untouched
    do_op(2'd0, 32'd6, 32'd7, 10, 10, cyc);
    check("stall_lat", cyc, 45);
    check("stall_lo", bus_if.lo, 42);
    check("stall_hi", bus_if.hi, 0);
    check("mul_keeps_dz", bus_if.div_zero, 1);

    // DIV -7 / 2
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, cyc);
`ifdef MULDIV_SIGNED_EN
    check("div_lo", bus_if.lo, 64'hFFFF_FFFD);
    check("div_hi", bus_if.hi, 64'hFFFF_FFFF);
`else
    check("div_lo", bus_if.lo, 64'h7FFF_FFFC);
    check("div_hi", bus_if.hi, 1);
`endif
    check("div_dz_clr", bus_if.div_zero, 0);

    // MULT -3 x 5
    do_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, cyc);
`ifdef MULDIV_SIGNED_EN
    check("mult_hi", bus_if.hi, 64'hFFFF_FFFF);
    check("mult_lo", bus_if.lo, 64'hFFFF_FFF1);
`else
    check("mult_hi", bus_if.hi, 4);
    check("mult_lo", bus_if.lo, 64'hFFFF_FFF1);
`endif

    // MTHI / MTLO in IDLE
    bus_if.hi_we      = 1'b1;
    bus_if.hilo_wdata = 32'hAAAA_0000;
    @(posedge clk); #1;
    bus_if.hi_we      = 1'b0;
    bus_if.lo_we      = 1'b1;
    bus_if.hilo_wdata = 32'h0000_5555;
    @(posedge clk); #1;
    bus_if.lo_we      = 1'b0;
    check("mthi", bus_if.hi, 64'hAAAA_0000);
    check("mtlo", bus_if.lo, 64'h0000_5555);

    // Reset in the 10th ITER cycle
    bus_if.start = 1'b1;
    bus_if.op    = 2'd0;
    bus_if.a     = 32'd6;
    bus_if.b     = 32'd7;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("hold_hi", bus_if.hi, 64'hAAAA_0000);
    check("mid_req", bus_if.alu_req, 1);
    reset = 1'b1;
    #1;
    check("arst_busy", bus_if.busy, 0);
    check("arst_req", bus_if.alu_req, 0);
    check("arst_done", bus_if.done, 0);
    check("arst_hi", bus_if.hi, 0);
    check("arst_lo", bus_if.lo, 0);
    check("arst_dz", bus_if.div_zero, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Start plus MTHI in the same cycle: start wins, write dropped
    bus_if.hi_we      = 1'b1;
    bus_if.hilo_wdata = 32'hDEAD_BEEF;
    do_op(2'd2, 32'd1000, 32'd10, 0, 0, cyc);
    check("post_lat", cyc, 35);
    check("post_lo", bus_if.lo, 100);
    check("post_hi", bus_if.hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
